// File: rtl/uart_pkg.sv
// Shared UART constants used by uart_rx and the receive-side buffer.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS     = 8;
   localparam int unsigned UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with extra-MSB pointers and fill level.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // a pop frees the slot the simultaneous push lands in, so full is no obstacle then
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive byte buffer: synchronizes the uart_rx frame-complete level, captures one
// byte per high period into a FIFO and streams it out with level and sticky overrun.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = UART_DATA_BITS,
   parameter int unsigned DEPTH     = UART_RX_FIFO_DEPTH,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                 sysclk_in,
   input  logic                 rst_in,
   input  logic                 data_rdy_in,
   input  logic [DATA_BITS-1:0] rx_data_in,
   output logic [DATA_BITS-1:0] m_data_out,
   output logic                 m_valid_out,
   input  logic                 m_ready_in,
   output logic [AW:0]          level_out,
   output logic                 overrun_out,
   input  logic                 clear_ovr_in
);

   logic s1, s2, s3;
   logic prime1, prime2;
   logic armed;
   logic push;
   logic pop;
   logic fifo_full;
   logic fifo_empty;
   logic ovr_set;

   always_ff @(posedge sysclk_in) begin
      if (rst_in) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= data_rdy_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // s2 only holds a real sample two edges after reset; arm on a genuine low
   always_ff @(posedge sysclk_in) begin
      if (rst_in) begin
         prime1 <= 1'b0;
         prime2 <= 1'b0;
         armed  <= 1'b0;
      end else begin
         prime1 <= 1'b1;
         prime2 <= prime1;
         if (prime2 && !s2) begin
            armed <= 1'b1;
         end
      end
   end

   assign push    = s2 & ~s3 & armed;
   assign pop     = m_valid_out & m_ready_in;
   assign ovr_set = push & fifo_full & ~pop;

   always_ff @(posedge sysclk_in) begin
      if (rst_in) begin
         overrun_out <= 1'b0;
      end else if (ovr_set) begin
         overrun_out <= 1'b1;
      end else if (clear_ovr_in) begin
         overrun_out <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (sysclk_in),
      .rst     (rst_in),
      .push    (push),
      .wr_data (rx_data_in),
      .pop     (pop),
      .rd_data (m_data_out),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level_out)
   );

   assign m_valid_out = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: latency, ordering, full/overrun and reset arming.
module tb_uart_rx_buffer;

   logic       sysclk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       data_rdy_in = 1'b0;
   logic [7:0] rx_data_in = '0;
   logic [7:0] m_data_out;
   logic       m_valid_out;
   logic       m_ready_in = 1'b0;
   logic [4:0] level_out;
   logic       overrun_out;
   logic       clear_ovr_in = 1'b0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   uart_rx_buffer #(
      .DATA_BITS (8),
      .DEPTH     (16)
   ) dut (
      .sysclk_in    (sysclk_in),
      .rst_in       (rst_in),
      .data_rdy_in  (data_rdy_in),
      .rx_data_in   (rx_data_in),
      .m_data_out   (m_data_out),
      .m_valid_out  (m_valid_out),
      .m_ready_in   (m_ready_in),
      .level_out    (level_out),
      .overrun_out  (overrun_out),
      .clear_ovr_in (clear_ovr_in)
   );

   always #5 sysclk_in = ~sysclk_in;

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge sysclk_in);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b);
      rx_data_in  = b;
      data_rdy_in = 1'b1;
      tick(4);
      data_rdy_in = 1'b0;
      tick(4);
   endtask

   task automatic test_reset;
      rst_in = 1'b1;
      tick(3);
      n_tests++;
      if (m_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", m_valid_out); end
      n_tests++;
      if (level_out !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level_out); end
      n_tests++;
      if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b exp=0", overrun_out); end
      rst_in = 1'b0;
      tick(4);
   endtask

   task automatic test_single_frame;
      rx_data_in  = 8'hA5;
      data_rdy_in = 1'b1;
      tick(2);
      n_tests++;
      if (m_valid_out !== 1'b0) begin n_fail++; $display("FAIL early_valid got=%b exp=0", m_valid_out); end
      tick(1);
      n_tests++;
      if (m_valid_out !== 1'b1 || m_data_out !== 8'hA5) begin
         n_fail++; $display("FAIL latency valid=%b data=%h exp valid=1 data=a5", m_valid_out, m_data_out);
      end
      tick(37);
      data_rdy_in = 1'b0;
      tick(4);
      n_tests++;
      if (level_out !== 5'd1) begin n_fail++; $display("FAIL one_push_level got=%0d exp=1", level_out); end
      m_ready_in = 1'b1;
      tick(1);
      m_ready_in = 1'b0;
      n_tests++;
      if (m_valid_out !== 1'b0 || level_out !== 5'd0) begin
         n_fail++; $display("FAIL pop_single valid=%b level=%0d exp 0/0", m_valid_out, level_out);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 5; i++) send_frame(8'(i));
      n_tests++;
      if (level_out !== 5'd5) begin n_fail++; $display("FAIL b2b_level got=%0d exp=5", level_out); end
      m_ready_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         n_tests++;
         if (m_valid_out !== 1'b1 || m_data_out !== 8'(i)) begin
            n_fail++; $display("FAIL b2b_out%0d valid=%b data=%h exp=%h", i, m_valid_out, m_data_out, 8'(i));
         end
         tick(1);
      end
      m_ready_in = 1'b0;
      n_tests++;
      if (m_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got=%b exp=0", m_valid_out); end
   endtask

   task automatic test_overrun;
      for (int i = 0; i < 16; i++) send_frame(8'h10 + 8'(i));
      n_tests++;
      if (level_out !== 5'd16) begin n_fail++; $display("FAIL fill_level got=%0d exp=16", level_out); end
      send_frame(8'hFF);
      n_tests++;
      if (overrun_out !== 1'b1 || level_out !== 5'd16 || m_data_out !== 8'h10) begin
         n_fail++; $display("FAIL overrun ovr=%b level=%0d head=%h exp 1/16/10", overrun_out, level_out, m_data_out);
      end
      clear_ovr_in = 1'b1;
      tick(1);
      clear_ovr_in = 1'b0;
      n_tests++;
      if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", overrun_out); end
   endtask

   task automatic test_full_push_pop;
      rx_data_in  = 8'hC4;
      data_rdy_in = 1'b1;
      tick(2);
      m_ready_in = 1'b1;
      tick(1);
      m_ready_in = 1'b0;
      n_tests++;
      if (level_out !== 5'd16 || m_data_out !== 8'h11 || overrun_out !== 1'b0) begin
         n_fail++; $display("FAIL full_pushpop level=%0d head=%h ovr=%b exp 16/11/0", level_out, m_data_out, overrun_out);
      end
      tick(2);
      data_rdy_in = 1'b0;
      tick(4);
      m_ready_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] exp_b;
         exp_b = (i < 15) ? 8'h11 + 8'(i) : 8'hC4;
         n_tests++;
         if (m_valid_out !== 1'b1 || m_data_out !== exp_b) begin
            n_fail++; $display("FAIL drain%0d valid=%b data=%h exp=%h", i, m_valid_out, m_data_out, exp_b);
         end
         tick(1);
      end
      m_ready_in = 1'b0;
      n_tests++;
      if (m_valid_out !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", m_valid_out); end
   endtask

   task automatic test_reset_while_high;
      send_frame(8'h99);
      rx_data_in  = 8'h77;
      data_rdy_in = 1'b1;
      tick(1);
      rst_in = 1'b1;
      tick(2);
      rst_in = 1'b0;
      tick(10);
      n_tests++;
      if (m_valid_out !== 1'b0 || level_out !== 5'd0) begin
         n_fail++; $display("FAIL rst_high valid=%b level=%0d exp 0/0", m_valid_out, level_out);
      end
      data_rdy_in = 1'b0;
      tick(4);
      send_frame(8'h3C);
      n_tests++;
      if (level_out !== 5'd1 || m_data_out !== 8'h3C) begin
         n_fail++; $display("FAIL rearm level=%0d data=%h exp 1/3c", level_out, m_data_out);
      end
      m_ready_in = 1'b1;
      tick(1);
      m_ready_in = 1'b0;
   endtask

   task automatic test_wraparound;
      logic [7:0]  q[$];
      int unsigned popped = 0;
      int unsigned errs = 0;
      for (int unsigned cyc = 0; cyc < 300; cyc++) begin
         int unsigned ph;
         logic        push_now, pop_now;
         ph = cyc % 6;
         if (cyc < 240) begin
            if (ph == 0) rx_data_in = 8'h40 + 8'(cyc / 6);
            data_rdy_in = (ph < 3);
         end else begin
            data_rdy_in = 1'b0;
         end
         m_ready_in = (cyc >= 250) ? 1'b1 : 1'($urandom_range(0, 1));
         n_tests++;
         if (m_valid_out !== (q.size() != 0) || level_out !== 5'(q.size()) ||
             (q.size() != 0 && m_data_out !== q[0])) begin
            n_fail++; errs++;
            if (errs < 8)
               $display("FAIL wrap_c%0d valid=%b level=%0d data=%h exp level=%0d head=%h",
                        cyc, m_valid_out, level_out, m_data_out, q.size(), (q.size() != 0) ? q[0] : 8'h00);
         end
         push_now = (cyc < 240) && (ph == 2);
         pop_now  = m_ready_in && (q.size() != 0);
         if (pop_now) begin
            void'(q.pop_front());
            popped++;
         end
         if (push_now && (q.size() < 16 || pop_now)) q.push_back(8'h40 + 8'(cyc / 6));
         tick(1);
      end
      m_ready_in = 1'b0;
      n_tests++;
      if (popped != 40 || overrun_out !== 1'b0) begin
         n_fail++; $display("FAIL wrap_total popped=%0d ovr=%b exp 40/0", popped, overrun_out);
      end
   endtask

   task automatic test_ovr_clear_collision;
      for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i));
      rx_data_in  = 8'hEE;
      data_rdy_in = 1'b1;
      tick(2);
      clear_ovr_in = 1'b1;
      tick(1);
      clear_ovr_in = 1'b0;
      n_tests++;
      if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear got=%b exp=1", overrun_out); end
      data_rdy_in = 1'b0;
      tick(4);
      n_tests++;
      if (level_out !== 5'd16 || m_data_out !== 8'h80) begin
         n_fail++; $display("FAIL ovr_contents level=%0d head=%h exp 16/80", level_out, m_data_out);
      end
      clear_ovr_in = 1'b1;
      tick(1);
      clear_ovr_in = 1'b0;
      n_tests++;
      if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2 got=%b exp=0", overrun_out); end
   endtask

   initial begin
      tick(1);
      test_reset;
      test_single_frame;
      test_back_to_back;
      test_overrun;
      test_full_push_pop;
      test_reset_while_high;
      test_wraparound;
      test_ovr_clear_collision;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
